// File: rtl/sccb_slave_regfile.sv
// sccb_slave_regfile
// Clock-oversampled SCCB (I2C-subset) slave that fronts an 8-bit register file.
// Handles 3-phase write, 2-phase write and 2-phase read, multi-byte bursts with
// a wrapping sub-address pointer, and repeated START. The host side gets a
// combinational read port plus a one-cycle write strobe for shadowing.
// Build option: define SCCB_ACK_EN to make the slave pull SIO_D low during the
// 9th bit of matched device, sub-address and write-data bytes.
module sccb_slave_regfile #(
  parameter logic [6:0] DEVICE_ID    = 7'h21,
  parameter int         REG_DEPTH    = 256,
  parameter logic [7:0] READ_DEFAULT = 8'hFF,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SIO_C,
  input  logic       SIO_D_in,
  output logic       SIO_D_oe,
  input  logic [7:0] host_addr,
  output logic [7:0] host_rdata,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    SUB,
    SUB_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK,
    IGNORE
  } state_t;

  state_t state, next_state;

  // Synchronised bus lines and their one-cycle-delayed copies
  logic [SYNC_STAGES-1:0] c_sync;
  logic [SYNC_STAGES-1:0] d_sync;
  logic                   c_prev;
  logic                   d_prev;
  logic                   scl;
  logic                   sda;

  // Bus events
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  // Byte assembly / transmission
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] byte_in;
  logic       byte_last;
  logic       rw_flag;
  logic [7:0] ptr;

  // Write path
  logic wr_commit;
  logic wr_hit;

  // Level SIO_D_oe takes at the next SIO_C falling edge
  logic drive_next;

  logic [7:0] regs [REG_DEPTH];

  // True when the address falls inside the implemented register range
  function automatic logic in_range(input logic [7:0] a);
    return (32'(a) < 32'(REG_DEPTH));
  endfunction

  // Register contents, or the default byte for unimplemented addresses
  function automatic logic [7:0] read_reg(input logic [7:0] a);
    return in_range(a) ? regs[a[AW-1:0]] : READ_DEFAULT;
  endfunction

  assign scl       = c_sync[SYNC_STAGES-1];
  assign sda       = d_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~c_prev;
  assign scl_fall  = ~scl & c_prev;
  assign start_det = scl & c_prev & d_prev & ~sda;
  assign stop_det  = scl & c_prev & ~d_prev & sda;

  assign byte_in   = {rx_shift, sda};
  assign byte_last = (bit_cnt == 3'd7);

  // A write byte completes on the 8th rising edge in WR; out-of-range addresses are dropped
  assign wr_commit = scl_rise && (state == WR) && byte_last;
  assign wr_hit    = wr_commit && in_range(ptr);

  // Synchronise both bus lines, then keep one extra stage for edge detection (idle bus is high)
  always_ff @(posedge clk) begin
    if (rst) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
      d_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], SIO_C};
      d_sync <= {d_sync[SYNC_STAGES-2:0], SIO_D_in};
      c_prev <= scl;
      d_prev <= sda;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state: STOP/START override everything, otherwise advance on SIO_C rising
  always_comb begin
    next_state = state;
    if (stop_det) begin
      next_state = IDLE;
    end else if (start_det) begin
      next_state = DEV;
    end else if (scl_rise) begin
      case (state)
        DEV: begin
          if (byte_last) begin
            next_state = (byte_in[7:1] == DEVICE_ID) ? DEV_ACK : IGNORE;
          end
        end
        DEV_ACK: next_state = rw_flag ? RD : SUB;
        SUB: begin
          if (byte_last) begin
            next_state = SUB_ACK;
          end
        end
        SUB_ACK: next_state = WR;
        WR: begin
          if (byte_last) begin
            next_state = WR_ACK;
          end
        end
        WR_ACK: next_state = WR;
        RD: begin
          if (byte_last) begin
            next_state = RD_ACK;
          end
        end
        RD_ACK: next_state = sda ? IGNORE : RD;
        default: next_state = state;
      endcase
    end
  end

  // FSM output: which level the slave should present on SIO_D for the upcoming bit
  always_comb begin
    drive_next = 1'b0;
    case (state)
      RD: drive_next = ~tx_shift[7];
`ifdef SCCB_ACK_EN
      DEV_ACK, SUB_ACK, WR_ACK: drive_next = 1'b1;
`else
      DEV_ACK, SUB_ACK, WR_ACK: drive_next = 1'b0;
`endif
      default: drive_next = 1'b0;
    endcase
  end

  // Bit counting, byte shifting and sub-address pointer; a START/STOP drops any partial byte
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
      rw_flag  <= 1'b0;
      ptr      <= 8'd0;
    end else if (start_det || stop_det) begin
      bit_cnt <= 3'd0;
    end else if (scl_rise) begin
      case (state)
        DEV, SUB, WR: begin
          rx_shift <= byte_in[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (byte_last) begin
            if (state == DEV) begin
              rw_flag <= sda;
            end
            if (state == SUB) begin
              ptr <= byte_in;
            end
            if (state == WR) begin
              ptr <= ptr + 8'd1;
            end
          end
        end
        DEV_ACK: begin
          if (rw_flag) begin
            tx_shift <= read_reg(ptr);
          end
        end
        RD: begin
          tx_shift <= {tx_shift[6:0], 1'b0};
          bit_cnt  <= bit_cnt + 3'd1;
          if (byte_last) begin
            ptr <= ptr + 8'd1;
          end
        end
        RD_ACK: begin
          if (!sda) begin
            tx_shift <= read_reg(ptr);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Register file storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (wr_hit) begin
      regs[ptr[AW-1:0]] <= byte_in;
    end
  end

  // Host write strobe, coincident with the register update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_valid <= 1'b0;
      wr_addr  <= 8'd0;
      wr_data  <= 8'd0;
    end else begin
      wr_valid <= wr_hit;
      if (wr_hit) begin
        wr_addr <= ptr;
        wr_data <= byte_in;
      end
    end
  end

  // Busy spans START detect to STOP detect
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (start_det) begin
      busy <= 1'b1;
    end else if (stop_det) begin
      busy <= 1'b0;
    end
  end

  // Open-drain enable only moves on SIO_C falling; bus conditions release it immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      SIO_D_oe <= 1'b0;
    end else if (start_det || stop_det) begin
      SIO_D_oe <= 1'b0;
    end else if (scl_fall) begin
      SIO_D_oe <= drive_next;
    end
  end

  // Host combinational read port
  always_comb begin
    host_rdata = read_reg(host_addr);
  end

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// tb_sccb_slave_regfile
// Directed bench for sccb_slave_regfile: a bit-banged SCCB master, a write
// scoreboard fed from the wr_valid strobe, a read scoreboard fed from bytes
// the master clocks out, and a reference copy of the register file.
module tb_sccb_slave_regfile;

  localparam int Q = 100;

`ifdef SCCB_ACK_EN
  localparam logic ACK_EXP = 1'b1;
`else
  localparam logic ACK_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       sio_d_in;
  logic       sio_d_oe;
  logic [7:0] host_addr;
  logic [7:0] host_rdata;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic [7:0]  model [256];
  logic        watch;
  logic        saw_drive;

  // Wired-AND of master and slave open-drain drivers
  assign sio_d_in = m_sda & ~sio_d_oe;

  sccb_slave_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .SIO_C      (scl),
    .SIO_D_in   (sio_d_in),
    .SIO_D_oe   (sio_d_oe),
    .host_addr  (host_addr),
    .host_rdata (host_rdata),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_host(input logic [7:0] a, input string tag);
    host_addr = a;
    #1;
    checkOutput(tag, 32'(host_rdata), 32'(model[a]));
  endtask

  task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
    wr_q.push_back({a, d});
    model[a] = d;
  endtask

  task automatic sccb_start();
    m_sda = 1'b1;
    #(Q);
    scl = 1'b1;
    #(Q);
    m_sda = 1'b0;
    #(Q);
    scl = 1'b0;
    #(Q);
  endtask

  task automatic sccb_stop();
    m_sda = 1'b0;
    #(Q);
    scl = 1'b1;
    #(Q);
    m_sda = 1'b1;
    #(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;
    #(Q);
    scl = 1'b1;
    #(2 * Q);
    scl = 1'b0;
    #(Q);
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1;
    #(Q);
    scl = 1'b1;
    #(Q);
    b = sio_d_in;
    #(Q);
    scl = 1'b0;
    #(Q);
  endtask

  // Master sends one byte, then samples the slave drive during the 9th bit
  task automatic applyStimulus(input logic [7:0] b, input logic ack_exp, input string tag);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
    end
    m_sda = 1'b1;
    #(Q);
    scl = 1'b1;
    #(Q);
    checkOutput({tag, "_ack"}, 32'(sio_d_oe), 32'(ack_exp));
    #(Q);
    scl = 1'b0;
    #(Q);
  endtask

  // Master clocks in one byte, answers ACK(0)/NA(1), and checks it against the read scoreboard
  task automatic read_byte(input logic nack, input string tag);
    logic [7:0] got;
    logic [7:0] exp_b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(got[i]);
    end
    send_bit(nack);
    if (rd_q.size() == 0) begin
      checkOutput({tag, "_no_expect"}, 32'(rd_q.size()), 1);
    end else begin
      exp_b = rd_q.pop_front();
      checkOutput(tag, 32'(got), 32'(exp_b));
    end
  endtask

  // Write scoreboard: every wr_valid cycle must match the next expected write
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (wr_valid) begin
      if (wr_q.size() == 0) begin
        checkOutput("wr_unexpected", 32'(wr_valid), 0);
      end else begin
        exp_w = wr_q.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(exp_w[15:8]));
        checkOutput("wr_data", 32'(wr_data), 32'(exp_w[7:0]));
      end
    end
  end

  // Sticky flag for any slave drive while a watch window is open
  always @(negedge clk) begin
    if (watch && sio_d_oe) begin
      saw_drive = 1'b1;
    end
  end

  initial begin
    logic [2:0] part;

    rst       = 1'b1;
    scl       = 1'b1;
    m_sda     = 1'b1;
    host_addr = 8'h0A;
    watch     = 1'b0;
    saw_drive = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model[i] = 8'h00;
    end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Reset state
    checkOutput("rst_oe", 32'(sio_d_oe), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    check_host(8'h0A, "rst_reg0A");

    // 3-phase write 0x42, 0x12, 0x80
    sccb_start();
    checkOutput("busy_after_start", 32'(busy), 1);
    applyStimulus(8'h42, ACK_EXP, "dev_w");
    applyStimulus(8'h12, ACK_EXP, "sub_12");
    exp_write(8'h12, 8'h80);
    applyStimulus(8'h80, ACK_EXP, "data_80");
    sccb_stop();
    repeat (4) @(negedge clk);
    checkOutput("busy_after_stop", 32'(busy), 0);
    check_host(8'h12, "reg12");

    // Seed 0x1C/0x1D, then 2-phase write to 0x1C followed by a 2-byte read
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_seed");
    applyStimulus(8'h1C, ACK_EXP, "sub_1C_seed");
    exp_write(8'h1C, 8'h5A);
    applyStimulus(8'h5A, ACK_EXP, "data_5A");
    exp_write(8'h1D, 8'hC3);
    applyStimulus(8'hC3, ACK_EXP, "data_C3");
    sccb_stop();
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_2ph");
    applyStimulus(8'h1C, ACK_EXP, "sub_1C_2ph");
    sccb_stop();
    sccb_start();
    applyStimulus(8'h43, ACK_EXP, "dev_r");
    rd_q.push_back(model[8'h1C]);
    read_byte(1'b0, "rd_1C");
    rd_q.push_back(model[8'h1D]);
    read_byte(1'b1, "rd_1D");
    sccb_stop();
    repeat (4) @(negedge clk);
    checkOutput("busy_after_read", 32'(busy), 0);

    // Burst write wrapping 0xFE -> 0xFF -> 0x00
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_burst");
    applyStimulus(8'hFE, ACK_EXP, "sub_FE");
    exp_write(8'hFE, 8'h11);
    applyStimulus(8'h11, ACK_EXP, "data_11");
    exp_write(8'hFF, 8'h22);
    applyStimulus(8'h22, ACK_EXP, "data_22");
    exp_write(8'h00, 8'h33);
    applyStimulus(8'h33, ACK_EXP, "data_33");
    sccb_stop();
    check_host(8'hFE, "regFE");
    check_host(8'hFF, "regFF");
    check_host(8'h00, "reg00");

    // Foreign device address 0x60: no drive, no write
    saw_drive = 1'b0;
    watch     = 1'b1;
    sccb_start();
    applyStimulus(8'hC0, 1'b0, "dev_bad");
    applyStimulus(8'h12, 1'b0, "bad_sub");
    applyStimulus(8'h99, 1'b0, "bad_data");
    sccb_stop();
    watch = 1'b0;
    checkOutput("no_drive_bad_addr", 32'(saw_drive), 0);
    check_host(8'h12, "reg12_untouched");

    // STOP after 4 data bits: no write and pointer left at the sub-address
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_30");
    applyStimulus(8'h30, ACK_EXP, "sub_30");
    exp_write(8'h30, 8'h77);
    applyStimulus(8'h77, ACK_EXP, "data_77");
    sccb_stop();
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_part");
    applyStimulus(8'h30, ACK_EXP, "sub_30_part");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    sccb_stop();
    check_host(8'h30, "reg30_after_partial");
    sccb_start();
    applyStimulus(8'h43, ACK_EXP, "dev_r_30");
    rd_q.push_back(model[8'h30]);
    read_byte(1'b1, "rd_30");
    sccb_stop();

    // Reset in the middle of a read of 0x80 while the slave is pulling SIO_D low
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_12");
    applyStimulus(8'h12, ACK_EXP, "sub_12_rd");
    sccb_stop();
    sccb_start();
    applyStimulus(8'h43, ACK_EXP, "dev_r_12");
    read_bit(part[2]);
    read_bit(part[1]);
    read_bit(part[0]);
    checkOutput("rd_partial_bits", 32'(part), 'h4);
    checkOutput("rd_drive_before_rst", 32'(sio_d_oe), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_read_oe", 32'(sio_d_oe), 0);
    checkOutput("rst_mid_read_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model[i] = 8'h00;
    end
    scl = 1'b1;
    #(Q);
    check_host(8'h12, "reg12_after_rst");

    // Slave is back in IDLE and accepts a fresh write
    sccb_start();
    applyStimulus(8'h42, ACK_EXP, "dev_w_post");
    applyStimulus(8'h05, ACK_EXP, "sub_05");
    exp_write(8'h05, 8'hA5);
    applyStimulus(8'hA5, ACK_EXP, "data_A5");
    sccb_stop();
    repeat (4) @(negedge clk);
    check_host(8'h05, "reg05");
    checkOutput("busy_end", 32'(busy), 0);
    checkOutput("wr_queue_drained", 32'(wr_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
